commit_trace_buffer: RTL and testbench

COMMIT_TRACE_BUFFER -- requirements
Module: commit_trace_buffer

---
 rtl/commit_trace_buffer.sv | 120 ++++++++++++
 tb/tb_commit_trace_buffer.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/commit_trace_buffer.sv
// Commit trace FIFO: captures retired instructions with a sequence number,
// flags dropped records on overflow and PC-chain discontinuities.
module commit_trace_buffer #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned SEQ_W = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       commit,
  input  logic [31:0]                commit_instr,
  input  logic [63:0]                commit_pc,
  input  logic [63:0]                commit_pre_pc,
  input  logic                       clear,
  output logic                       trace_valid,
  input  logic                       trace_ready,
  output logic [31:0]                trace_instr,
  output logic [63:0]                trace_pc,
  output logic [63:0]                trace_npc,
  output logic [SEQ_W-1:0]           trace_seq,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       overflow,
  output logic [15:0]                drop_cnt,
  output logic                       mismatch,
  output logic [63:0]                mismatch_pc
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  logic [31:0]      mem_instr [DEPTH];
  logic [63:0]      mem_pc    [DEPTH];
  logic [63:0]      mem_npc   [DEPTH];
  logic [SEQ_W-1:0] mem_seq   [DEPTH];

  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [SEQ_W-1:0] seq;
  logic [63:0]      exp_pc;
  logic             exp_valid;

  logic full, pop, push, drop, mismatch_now;

  always_comb begin
    full         = (level == LW'(DEPTH));
    pop          = trace_valid && trace_ready;
    push         = commit && (!full || pop);
    drop         = commit && full && !pop;
    mismatch_now = commit && exp_valid && (commit_pc != exp_pc);
  end

  assign trace_valid = (level != '0);
  assign trace_instr = mem_instr[rd_ptr];
  assign trace_pc    = mem_pc[rd_ptr];
  assign trace_npc   = mem_npc[rd_ptr];
  assign trace_seq   = mem_seq[rd_ptr];

  // Storage carries no reset: contents are don't-care until level covers them.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_instr[wr_ptr] <= commit_instr;
      mem_pc[wr_ptr]    <= commit_pc;
      mem_npc[wr_ptr]   <= commit_pre_pc;
      mem_seq[wr_ptr]   <= seq;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      seq       <= '0;
      exp_pc    <= '0;
      exp_valid <= 1'b0;
    end else if (commit) begin
      seq       <= seq + 1'b1;
      exp_pc    <= commit_pre_pc;
      exp_valid <= 1'b1;
    end
  end

  // Clear is applied first so a same-cycle drop or mismatch lands on top of it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      overflow    <= 1'b0;
      drop_cnt    <= '0;
      mismatch    <= 1'b0;
      mismatch_pc <= '0;
    end else begin
      if (clear) begin
        overflow    <= 1'b0;
        drop_cnt    <= '0;
        mismatch    <= 1'b0;
        mismatch_pc <= '0;
      end
      if (drop) begin
        overflow <= 1'b1;
        if (clear)                  drop_cnt <= 16'd1;
        else if (drop_cnt != '1)    drop_cnt <= drop_cnt + 1'b1;
      end
      if (mismatch_now) begin
        mismatch <= 1'b1;
        if (!mismatch || clear) mismatch_pc <= commit_pc;
      end
    end
  end

endmodule

// File: tb/tb_commit_trace_buffer.sv
// Scoreboard bench for commit_trace_buffer: directed scenarios plus random
// traffic checked against a queue-based reference model.
module tb_commit_trace_buffer;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned LW    = $clog2(DEPTH) + 1;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        commit = 1'b0;
  logic [31:0] commit_instr = '0;
  logic [63:0] commit_pc = '0;
  logic [63:0] commit_pre_pc = '0;
  logic        clear = 1'b0;
  logic        trace_valid;
  logic        trace_ready = 1'b0;
  logic [31:0] trace_instr;
  logic [63:0] trace_pc;
  logic [63:0] trace_npc;
  logic [31:0] trace_seq;
  logic [LW-1:0] level;
  logic        overflow;
  logic [15:0] drop_cnt;
  logic        mismatch;
  logic [63:0] mismatch_pc;

  commit_trace_buffer #(.DEPTH(DEPTH), .SEQ_W(32)) dut (
    .clk(clk), .rst(rst), .commit(commit), .commit_instr(commit_instr),
    .commit_pc(commit_pc), .commit_pre_pc(commit_pre_pc), .clear(clear),
    .trace_valid(trace_valid), .trace_ready(trace_ready),
    .trace_instr(trace_instr), .trace_pc(trace_pc), .trace_npc(trace_npc),
    .trace_seq(trace_seq), .level(level), .overflow(overflow),
    .drop_cnt(drop_cnt), .mismatch(mismatch), .mismatch_pc(mismatch_pc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic [63:0] pc;
    logic [63:0] npc;
    logic [31:0] seq;
  } rec_t;

  rec_t sb[$];
  int   checks = 0;
  int   errors = 0;

  // reference model state
  int          m_level;
  logic [31:0] m_seq;
  logic        m_expv;
  logic [63:0] m_exp_pc;
  logic        m_ovf;
  int          m_drop;
  logic        m_mm;
  logic [63:0] m_mpc;
  logic [63:0] nxt;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
    end
  endtask

  task automatic check_state();
    chk("level", 64'(level), 64'(m_level));
    chk("trace_valid", 64'(trace_valid), 64'(m_level != 0));
    chk("overflow", 64'(overflow), 64'(m_ovf));
    chk("drop_cnt", 64'(drop_cnt), 64'(m_drop));
    chk("mismatch", 64'(mismatch), 64'(m_mm));
    chk("mismatch_pc", mismatch_pc, m_mpc);
  endtask

  task automatic model_reset();
    sb.delete();
    m_level = 0; m_seq = '0; m_expv = 1'b0; m_exp_pc = '0;
    m_ovf = 1'b0; m_drop = 0; m_mm = 1'b0; m_mpc = '0;
  endtask

  // Entered at posedge+2; asserts reset off-edge and checks it acts without a clock.
  task automatic do_reset();
    #1;
    rst = 1'b0; commit = 1'b0; clear = 1'b0; trace_ready = 1'b0;
    model_reset();
    #1;
    check_state();
    @(posedge clk); #2;
    rst = 1'b1;
  endtask

  // Drive one cycle of inputs, advance the model to the next edge, check after it.
  task automatic step(input logic c, input logic [31:0] ins, input logic [63:0] p,
                      input logic [63:0] np, input logic rdy, input logic clr);
    logic pop, full, push, drop, mm;
    commit = c; commit_instr = ins; commit_pc = p; commit_pre_pc = np;
    trace_ready = rdy; clear = clr;
    pop  = (m_level != 0) && rdy;
    full = (m_level == DEPTH);
    push = c && (!full || pop);
    drop = c && full && !pop;
    mm   = c && m_expv && (p != m_exp_pc);
    if (push) sb.push_back('{ins, p, np, m_seq});
    m_level = m_level + int'(push) - int'(pop);
    if (c) begin
      m_seq    = m_seq + 1;
      m_expv   = 1'b1;
      m_exp_pc = np;
    end
    if (clr) begin
      m_ovf = 1'b0; m_drop = 0; m_mm = 1'b0; m_mpc = '0;
    end
    if (drop) begin
      m_ovf = 1'b1;
      if (m_drop < 65535) m_drop++;
    end
    if (mm) begin
      if (!m_mm) m_mpc = p;
      m_mm = 1'b1;
    end
    @(posedge clk); #1;
    check_state();
    #1;
  endtask

  task automatic commit_chain(input logic rdy);
    step(1'b1, $urandom, nxt, nxt + 64'd4, rdy, 1'b0);
    nxt = nxt + 64'd4;
  endtask

  task automatic idle(input logic rdy);
    step(1'b0, '0, '0, '0, rdy, 1'b0);
  endtask

  // Monitor: compare the presented head against the scoreboard front.
  always @(negedge clk) begin
    if (rst && trace_valid) begin
      if (sb.size() == 0) begin
        chk("sb_nonempty", 64'd0, 64'd1);
      end else begin
        chk("trace_instr", 64'(trace_instr), 64'(sb[0].instr));
        chk("trace_pc", trace_pc, sb[0].pc);
        chk("trace_npc", trace_npc, sb[0].npc);
        chk("trace_seq", 64'(trace_seq), 64'(sb[0].seq));
        if (trace_ready) void'(sb.pop_front());
      end
    end
  end

  initial begin
    logic rdy_bias;
    model_reset();
    #2;
    do_reset();

    // single commit with ready high
    nxt = 64'h8000_0000;
    commit_chain(1'b1);
    chk("single_valid", 64'(trace_valid), 64'd1);
    chk("single_seq", 64'(trace_seq), 64'd0);
    idle(1'b1);
    chk("single_valid_drop", 64'(trace_valid), 64'd0);
    chk("single_level", 64'(level), 64'd0);

    // overflow: 10 commits into a stalled FIFO, then drain
    do_reset();
    nxt = 64'h8000_0000;
    repeat (10) commit_chain(1'b0);
    chk("ovf_level", 64'(level), 64'd8);
    chk("ovf_flag", 64'(overflow), 64'd1);
    chk("ovf_drop_cnt", 64'(drop_cnt), 64'd2);
    repeat (9) idle(1'b1);

    // full FIFO with simultaneous push and pop
    do_reset();
    nxt = 64'h1_0000;
    repeat (8) commit_chain(1'b0);
    repeat (4) begin
      commit_chain(1'b1);
      chk("full_pp_level", 64'(level), 64'd8);
    end
    chk("full_pp_seq", 64'(trace_seq), 64'd4);
    chk("full_pp_drops", 64'(drop_cnt), 64'd0);
    repeat (9) idle(1'b1);

    // PC-chain mismatch capture and clear
    do_reset();
    step(1'b1, 32'h13, 64'h1000, 64'h1004, 1'b1, 1'b0);
    step(1'b1, 32'h13, 64'h2000, 64'h2004, 1'b1, 1'b0);
    chk("mm_flag", 64'(mismatch), 64'd1);
    chk("mm_pc", mismatch_pc, 64'h2000);
    step(1'b1, 32'h13, 64'h3000, 64'h3004, 1'b1, 1'b0);
    chk("mm_pc_held", mismatch_pc, 64'h2000);
    step(1'b0, '0, '0, '0, 1'b1, 1'b1);
    chk("mm_cleared", 64'(mismatch), 64'd0);
    chk("mm_pc_cleared", mismatch_pc, 64'd0);
    idle(1'b1);

    // reset mid-drain
    do_reset();
    nxt = 64'h4000;
    repeat (5) commit_chain(1'b0);
    chk("pre_rst_level", 64'(level), 64'd5);
    idle(1'b1);
    do_reset();
    chk("rst_level", 64'(level), 64'd0);
    chk("rst_valid", 64'(trace_valid), 64'd0);
    step(1'b1, 32'hABCD, 64'h5555_0000, 64'h5555_0004, 1'b0, 1'b0);
    chk("post_rst_seq", 64'(trace_seq), 64'd0);
    chk("post_rst_nomm", 64'(mismatch), 64'd0);
    repeat (2) idle(1'b1);

    // random traffic
    nxt = 64'h8000_0000;
    rdy_bias = 1'b1;
    for (int i = 0; i < 1500; i++) begin
      logic c, rdy, clr, bad;
      logic [63:0] p, np;
      if (i % 64 == 0) rdy_bias = ($urandom_range(0, 2) != 0);
      c   = ($urandom_range(0, 9) < 7);
      rdy = rdy_bias ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 7) == 0);
      clr = ($urandom_range(0, 29) == 0);
      bad = ($urandom_range(0, 19) == 0);
      p   = bad ? (nxt ^ 64'h100) : nxt;
      np  = ($urandom_range(0, 7) == 0) ? {32'h0, $urandom & 32'hFFFF_FFFC} : p + 64'd4;
      step(c, $urandom, p, np, rdy, clr);
      if (c) nxt = np;
    end
    repeat (DEPTH + 2) idle(1'b1);
    chk("sb_drained", 64'(sb.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
